// File: rtl/serial_add_scheduler.sv
// Round-robin front end that time-shares one external bit-serial adder.
// Define SERIAL_ADD_SCHED_PAUSE_EN to add the pause input (stalls streaming).
module serial_add_scheduler #(
    parameter  int W    = 8,
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_vld,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              resp_vld,
    input  logic              resp_rdy,
    output logic [W-1:0]      resp_data,
    output logic [IDW-1:0]    resp_id,
    output logic              add_vld,
    output logic              add_a,
    output logic              add_b,
    output logic              add_last,
    input  logic              add_sum,
`ifdef SERIAL_ADD_SCHED_PAUSE_EN
    input  logic              pause,
`endif
    output logic              busy
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  id;
    logic [IDW-1:0]  gidx;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    res;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [NREQ-1:0] grant;
    logic            found;
    logic            run;

`ifdef SERIAL_ADD_SCHED_PAUSE_EN
    assign run = !pause;
`else
    assign run = 1'b1;
`endif

    // Scan starting at rr_ptr so the last winner gets lowest priority.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        gidx  = '0;
        a_sel = '0;
        b_sel = '0;
        grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rr_ptr) + k) % NREQ;
            if (!found && req_vld[j]) begin
                found    = 1'b1;
                gidx     = IDW'(j);
                a_sel    = req_a[j*W +: W];
                b_sel    = req_b[j*W +: W];
                grant[j] = 1'b1;
            end
        end
    end

    assign req_rdy   = (state == IDLE) ? grant : '0;
    assign add_vld   = (state == SHIFT) && run;
    assign add_a     = (state == SHIFT) && a_sh[0];
    assign add_b     = (state == SHIFT) && b_sh[0];
    assign add_last  = add_vld && (cnt == CW'(W - 1));
    assign resp_vld  = (state == RESP);
    assign resp_data = res;
    assign resp_id   = id;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            id     <= '0;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        a_sh   <= a_sel;
                        b_sh   <= b_sel;
                        id     <= gidx;
                        rr_ptr <= (gidx == IDW'(NREQ - 1)) ? '0
                                                           : gidx + IDW'(1);
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (add_vld) begin
                        res  <= {add_sum, res[W-1:1]};
                        a_sh <= a_sh >> 1;
                        b_sh <= b_sh >> 1;
                        cnt  <= cnt + CW'(1);
                        if (add_last) state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_rdy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Bench for serial_add_scheduler with a bit-serial adder model and
// a cycle-level transaction model of the expected port behaviour.
module tb_serial_add_scheduler;

    localparam int W    = 8;
    localparam int NREQ = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_vld = '0;
    logic [1:0]  req_rdy;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        resp_vld;
    logic        resp_rdy = 1'b1;
    logic [7:0]  resp_data;
    logic [0:0]  resp_id;
    logic        add_vld, add_a, add_b, add_last, add_sum, busy;
    logic        pause = 1'b0;
    logic        carry;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_add_scheduler #(.W(W), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_a(req_a), .req_b(req_b),
        .resp_vld(resp_vld), .resp_rdy(resp_rdy),
        .resp_data(resp_data), .resp_id(resp_id),
        .add_vld(add_vld), .add_a(add_a), .add_b(add_b),
        .add_last(add_last), .add_sum(add_sum),
`ifdef SERIAL_ADD_SCHED_PAUSE_EN
        .pause(pause),
`endif
        .busy(busy)
    );

    // External serial adder: carry held across gaps, cleared after last.
    assign add_sum = add_a ^ add_b ^ carry;
    always @(posedge clk or negedge rst) begin
        if (!rst) carry <= 1'b0;
        else if (add_vld)
            carry <= add_last ? 1'b0
                              : (add_a & add_b) | (carry & (add_a ^ add_b));
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Transaction model state
    bit         m_pend = 0;
    bit         m_first = 0;
    int         m_nb = 0;
    int         m_ptr = 0;
    int         m_acc = 0;
    int         m_id = 0;
    int         m_last = 0;
    int         lat_last = 0;
    int         last_cnt = 0;
    logic [7:0] m_a = '0;
    logic [7:0] m_b = '0;
    int         id_log[$];
    logic [7:0] data_log[$];

    always @(negedge clk) begin : mon
        logic [1:0] er;
        logic       ev, el, ea, eb, rv;
        int         g;
        if (!rst) begin
            m_pend = 0;
            m_ptr  = 0;
        end else begin
            er = '0;
            if (!m_pend)
                for (int k = 0; k < NREQ; k++)
                    if (er == '0 && req_vld[(m_ptr + k) % NREQ])
                        er[(m_ptr + k) % NREQ] = 1'b1;
            ev = 0; el = 0; ea = 0; eb = 0;
            if (m_pend && m_nb < W) begin
                ev = !pause;
                ea = m_a[m_nb];
                eb = m_b[m_nb];
                el = !pause && (m_nb == W - 1);
            end
            rv = m_pend && (m_nb == W);
            chk("req_rdy", req_rdy, er);
            chk("rdy_onehot", $onehot0(req_rdy), 1);
            chk("busy", busy, m_pend);
            chk("add_vld", add_vld, ev);
            chk("add_a", add_a, ea);
            chk("add_b", add_b, eb);
            chk("add_last", add_last, el);
            chk("resp_vld", resp_vld, rv);
            if (add_last) m_last++;
            if (ev) m_nb++;
            if (rv && resp_vld) begin
                if (m_first) begin
                    lat_last = cyc - m_acc;
                    m_first  = 0;
                end
                chk("resp_data", resp_data, 8'(m_a + m_b));
                chk("resp_id", resp_id, m_id);
                if (resp_rdy) begin
                    data_log.push_back(resp_data);
                    id_log.push_back(m_id);
                    last_cnt = m_last;
                    m_pend   = 0;
                end
            end else if (!m_pend && |(req_vld & req_rdy)) begin
                g = 0;
                for (int k = 0; k < NREQ; k++)
                    if (req_rdy[k]) g = k;
                m_a     = req_a[g*W +: W];
                m_b     = req_b[g*W +: W];
                m_id    = g;
                m_ptr   = (g + 1) % NREQ;
                m_pend  = 1;
                m_nb    = 0;
                m_acc   = cyc;
                m_first = 1;
                m_last  = 0;
            end
        end
    end

    task automatic do_req(input int i, input logic [7:0] a,
                          input logic [7:0] b);
        bit got;
        got = 0;
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_vld[i] = 1'b1;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            if (req_rdy[i]) got = 1;
        end
        chk("grant_wait", got, 1);
        @(posedge clk);
        #1;
        req_vld[i] = 1'b0;
    endtask

    task automatic wait_resp(input int n, input string nm);
        for (int t = 0; t < 300 && id_log.size() < n; t++)
            @(negedge clk);
        chk(nm, id_log.size(), n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] ta0 [2] = '{8'h11, 8'hF0};
    logic [7:0] tb0 [2] = '{8'h22, 8'h20};
    logic [7:0] ta1 [2] = '{8'h05, 8'h7F};
    logic [7:0] tb1 [2] = '{8'h06, 8'h7F};

    initial begin
        int n0, n1;
        logic [1:0] g;
        #12;
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_resp_vld", resp_vld, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_add_vld", add_vld, 0);
        chk("rst_add_ab", {add_a, add_b, add_last}, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // basic add, latency and single last pulse
        do_req(0, 8'h35, 8'h4A);
        wait_resp(1, "t1_done");
        chk("t1_data", data_log[0], 8'h7F);
        chk("t1_id", id_log[0], 0);
        chk("t1_lat", lat_last, 9);
        chk("t1_last_cnt", last_cnt, 1);

        // wrap-around, then carry must have been cleared
        do_req(1, 8'hFF, 8'h01);
        wait_resp(2, "t2a_done");
        do_req(1, 8'h01, 8'h01);
        wait_resp(3, "t2b_done");
        chk("t2_wrap", data_log[1], 8'h00);
        chk("t2_after", data_log[2], 8'h02);

        // response back-pressure
        resp_rdy = 1'b0;
        do_req(1, 8'h12, 8'h34);
        for (int t = 0; t < 50 && !resp_vld; t++) begin
            @(posedge clk); #1;
        end
        req_a[15:8] = 8'h80;
        req_b[15:8] = 8'h80;
        req_vld[1]  = 1'b1;
        repeat (5) begin
            chk("t4_data", resp_data, 8'h46);
            chk("t4_id", resp_id, 1);
            chk("t4_rdy", req_rdy, 0);
            chk("t4_add_vld", add_vld, 0);
            @(posedge clk); #1;
        end
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        chk("t4_idle", busy, 0);
        chk("t4_grant", req_rdy, 2'b10);
        @(posedge clk); #1;
        req_vld[1] = 1'b0;
        wait_resp(5, "t4_done");
        chk("t4_data_log", data_log[3], 8'h46);
        chk("t4_wrap_log", data_log[4], 8'h00);

        // round robin with both requesters always pending
        n0 = 0;
        n1 = 0;
        req_a = {ta1[0], ta0[0]};
        req_b = {tb1[0], tb0[0]};
        req_vld = 2'b11;
        for (int t = 0; t < 200 && (n0 < 2 || n1 < 2); t++) begin
            @(negedge clk);
            g = req_rdy;
            @(posedge clk); #1;
            if (g[0]) begin
                n0++;
                if (n0 < 2) begin
                    req_a[7:0] = ta0[n0];
                    req_b[7:0] = tb0[n0];
                end else req_vld[0] = 1'b0;
            end
            if (g[1]) begin
                n1++;
                if (n1 < 2) begin
                    req_a[15:8] = ta1[n1];
                    req_b[15:8] = tb1[n1];
                end else req_vld[1] = 1'b0;
            end
        end
        req_vld = 2'b00;
        wait_resp(9, "t3_done");
        chk("t3_id0", id_log[5], 0);
        chk("t3_id1", id_log[6], 1);
        chk("t3_id2", id_log[7], 0);
        chk("t3_id3", id_log[8], 1);
        chk("t3_d0", data_log[5], 8'h33);
        chk("t3_d1", data_log[6], 8'h0B);
        chk("t3_d2", data_log[7], 8'h10);
        chk("t3_d3", data_log[8], 8'hFE);

        // reset during SHIFT
        do_req(0, 8'h55, 8'h11);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("t5_add_vld", add_vld, 0);
        chk("t5_add_last", add_last, 0);
        chk("t5_add_ab", {add_a, add_b}, 0);
        chk("t5_busy", busy, 0);
        chk("t5_resp_vld", resp_vld, 0);
        chk("t5_resp_data", resp_data, 0);
        chk("t5_resp_id", resp_id, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        req_a = {8'h99, 8'h10};
        req_b = {8'h01, 8'h20};
        req_vld = 2'b11;
        @(negedge clk);
        chk("t5_ptr0", req_rdy, 2'b01);
        @(posedge clk); #1;
        req_vld = 2'b00;
        wait_resp(10, "t5_done");
        chk("t5_data", data_log[9], 8'h30);
        chk("t5_id", id_log[9], 0);

`ifdef SERIAL_ADD_SCHED_PAUSE_EN
        // pause gap after bit 1
        do_req(0, 8'h0F, 8'h01);
        @(posedge clk); #1;
        pause = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        pause = 1'b0;
        wait_resp(11, "t6_done");
        chk("t6_data", data_log[10], 8'h10);
        chk("t6_lat", lat_last, 12);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
